// File: rtl/mmio_io_bridge.sv
// Memory-mapped I/O bridge between the CPU load/store path and board peripherals:
// switches, LEDs, 7-segment word and radix, debounced buttons with W1C pending bits, key FIFO.
module mmio_io_bridge #(
    parameter logic [31:0] ADDR_BASE  = 32'hFFFF_FC00,
    parameter int          SW_W       = 12,
    parameter int          LED_W      = 16,
    parameter int          NUM_BTN    = 4,
    parameter int          DEB_CYCLES = 200000,
    parameter int          KEY_W      = 4,
    parameter int          KEY_DEPTH  = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               io_read,
    input  logic               io_write,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    input  logic [SW_W-1:0]    switch_in,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic [KEY_W-1:0]   key_data,
    input  logic               key_valid,
    output logic [LED_W-1:0]   led_out,
    output logic [31:0]        seg_data,
    output logic               seg_base,
    output logic               key_pending
);

    localparam int PTR_W = $clog2(KEY_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [2:0] {
        REG_SW       = 3'd0,
        REG_LED      = 3'd1,
        REG_SEG      = 3'd2,
        REG_SEGCTRL  = 3'd3,
        REG_BTN_PEND = 3'd4,
        REG_BTN_CLR  = 3'd5,
        REG_KEY_DATA = 3'd6,
        REG_KEY_STAT = 3'd7
    } reg_sel_e;

    logic     hit;
    reg_sel_e sel;
    logic     wr_en;

    assign hit   = (addr[31:5] == ADDR_BASE[31:5]);
    assign sel   = reg_sel_e'(addr[4:2]);
    assign wr_en = io_write && hit;

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata};

    logic [SW_W-1:0]    sw_meta, sw_sync;
    logic [NUM_BTN-1:0] btn_meta, btn_sync, btn_acc, btn_pend;
    logic [NUM_BTN-1:0] btn_accept, btn_clr;
    logic [DEB_W-1:0]   deb_cnt [NUM_BTN];

    logic [KEY_W-1:0]   key_mem [KEY_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   key_cnt;
    logic               key_full, key_empty, key_push, key_pop, overflow;
    logic               ovf_set, ovf_clr;

    assign key_full    = (key_cnt == CNT_W'(KEY_DEPTH));
    assign key_empty   = (key_cnt == '0);
    assign key_pop     = io_read && hit && (sel == REG_KEY_DATA) && !key_empty;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the new code.
    assign key_push    = key_valid && (!key_full || key_pop);
    assign ovf_set     = key_valid && key_full && !key_pop;
    assign ovf_clr     = wr_en && (sel == REG_KEY_STAT);
    assign key_pending = !key_empty;

    always_comb begin
        btn_clr    = (wr_en && sel == REG_BTN_CLR) ? wdata[NUM_BTN-1:0] : '0;
        btn_accept = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            btn_accept[i] = (btn_sync[i] != btn_acc[i]) && (deb_cnt[i] == DEB_LAST);
        end
    end

    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led_out  <= '0;
            seg_data <= '0;
            seg_base <= 1'b0;
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
            btn_acc  <= '0;
            btn_pend <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sw_meta  <= switch_in;
            sw_sync  <= sw_meta;
            btn_meta <= btn_in;
            btn_sync <= btn_meta;
            if (wr_en && sel == REG_LED)     led_out  <= wdata[LED_W-1:0];
            if (wr_en && sel == REG_SEG)     seg_data <= wdata;
            if (wr_en && sel == REG_SEGCTRL) seg_base <= wdata[0];
            for (int i = 0; i < NUM_BTN; i++) begin
                if (btn_sync[i] == btn_acc[i] || btn_accept[i]) deb_cnt[i] <= '0;
                else                                            deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
            end
            btn_acc  <= btn_acc ^ btn_accept;
            // Set is OR-ed after the clear so a coinciding rising edge wins.
            btn_pend <= (btn_pend & ~btn_clr) | (btn_accept & btn_sync);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            key_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (key_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (key_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({key_push, key_pop})
                2'b10:   key_cnt <= key_cnt + CNT_W'(1);
                2'b01:   key_cnt <= key_cnt - CNT_W'(1);
                default: ;
            endcase
            overflow <= ovf_set || (overflow && !ovf_clr);
        end
    end

    // NOTE: storage array is not reset; count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (key_push) key_mem[wr_ptr] <= key_data;
    end

    // NOTE: rdata defaults to zero first so no decode path leaves it unassigned.
    always_comb begin
        rdata = '0;
        if (io_read && hit) begin
            case (sel)
                REG_SW:       rdata = 32'(sw_sync);
                REG_LED:      rdata = 32'(led_out);
                REG_SEG:      rdata = seg_data;
                REG_SEGCTRL:  rdata = {31'b0, seg_base};
                REG_BTN_PEND: rdata = 32'(btn_pend);
                REG_BTN_CLR:  rdata = '0;
                REG_KEY_DATA: rdata = key_empty ? '0 : 32'(key_mem[rd_ptr]);
                REG_KEY_STAT: rdata = {16'b0, 8'(key_cnt), 4'b0, overflow, key_full, key_empty, 1'b0};
                default:      rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_io_bridge.sv
// Self-checking bench for mmio_io_bridge: directed scenarios plus randomized traffic
// compared against a queue/arithmetic reference model of the register map.
module tb_mmio_io_bridge;

    localparam int          SW_W      = 12;
    localparam int          LED_W     = 16;
    localparam int          NUM_BTN   = 4;
    localparam int          DEB       = 8;
    localparam int          KEY_W     = 4;
    localparam int          DEPTH     = 4;
    localparam logic [31:0] BASE      = 32'hFFFF_FC00;
    localparam logic [31:0] A_SW      = 32'hFFFF_FC00;
    localparam logic [31:0] A_LED     = 32'hFFFF_FC04;
    localparam logic [31:0] A_SEG     = 32'hFFFF_FC08;
    localparam logic [31:0] A_SEGCTRL = 32'hFFFF_FC0C;
    localparam logic [31:0] A_PEND    = 32'hFFFF_FC10;
    localparam logic [31:0] A_CLR     = 32'hFFFF_FC14;
    localparam logic [31:0] A_KEY     = 32'hFFFF_FC18;
    localparam logic [31:0] A_STAT    = 32'hFFFF_FC1C;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               io_read = 1'b0;
    logic               io_write = 1'b0;
    logic [31:0]        addr = '0;
    logic [31:0]        wdata = '0;
    logic [31:0]        rdata;
    logic [SW_W-1:0]    switch_in = '0;
    logic [NUM_BTN-1:0] btn_in = '0;
    logic [KEY_W-1:0]   key_data = '0;
    logic               key_valid = 1'b0;
    logic [LED_W-1:0]   led_out;
    logic [31:0]        seg_data;
    logic               seg_base;
    logic               key_pending;

    int checks = 0;
    int errors = 0;

    mmio_io_bridge #(
        .ADDR_BASE (BASE),
        .SW_W      (SW_W),
        .LED_W     (LED_W),
        .NUM_BTN   (NUM_BTN),
        .DEB_CYCLES(DEB),
        .KEY_W     (KEY_W),
        .KEY_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .io_read    (io_read),
        .io_write   (io_write),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .switch_in  (switch_in),
        .btn_in     (btn_in),
        .key_data   (key_data),
        .key_valid  (key_valid),
        .led_out    (led_out),
        .seg_data   (seg_data),
        .seg_base   (seg_base),
        .key_pending(key_pending)
    );

    always #5 clk = ~clk;

    // Reference model: register values, a queue for the key FIFO, and per-button
    // runs of consecutive synchronised samples that disagree with the accepted level.
    logic [LED_W-1:0]   m_led;
    logic [31:0]        m_seg;
    logic               m_base;
    logic [SW_W-1:0]    m_sw1, m_sw2;
    logic [NUM_BTN-1:0] m_b1, m_b2, m_acc, m_pend;
    int                 m_run [NUM_BTN];
    int unsigned        m_keys [$];
    logic               m_ovf;

    always @(posedge clk or negedge rstn) begin : model
        logic           m_hit;
        logic [2:0]     m_sel;
        int             n;
        bit             pop;
        logic [NUM_BTN-1:0] clr, set;
        if (!rstn) begin
            m_led = '0; m_seg = '0; m_base = 1'b0;
            m_sw1 = '0; m_sw2 = '0;
            m_b1 = '0; m_b2 = '0; m_acc = '0; m_pend = '0;
            for (int i = 0; i < NUM_BTN; i++) m_run[i] = 0;
            m_keys.delete();
            m_ovf = 1'b0;
        end else begin
            m_hit = (addr[31:5] == BASE[31:5]);
            m_sel = addr[4:2];
            n     = m_keys.size();
            pop   = io_read && m_hit && (m_sel == 3'd6) && (n > 0);
            clr   = '0;
            set   = '0;
            if (io_write && m_hit) begin
                case (m_sel)
                    3'd1: m_led  = wdata[LED_W-1:0];
                    3'd2: m_seg  = wdata;
                    3'd3: m_base = wdata[0];
                    3'd5: clr    = wdata[NUM_BTN-1:0];
                    3'd7: m_ovf  = 1'b0;
                    default: ;
                endcase
            end
            if (pop) void'(m_keys.pop_front());
            if (key_valid) begin
                if (n < DEPTH || pop) m_keys.push_back(int'(key_data));
                else                  m_ovf = 1'b1;
            end
            for (int i = 0; i < NUM_BTN; i++) begin
                if (m_b2[i] != m_acc[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_acc[i] = m_b2[i];
                        m_run[i] = 0;
                        if (m_acc[i]) set[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_pend = (m_pend & ~clr) | set;
            m_b2 = m_b1; m_b1 = btn_in;
            m_sw2 = m_sw1; m_sw1 = switch_in;
        end
    end

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        int n;
        n = m_keys.size();
        if (a[31:5] != BASE[31:5]) return 32'h0;
        case (a[4:2])
            3'd0: return 32'(m_sw2);
            3'd1: return 32'(m_led);
            3'd2: return m_seg;
            3'd3: return 32'(m_base);
            3'd4: return 32'(m_pend);
            3'd6: return (n > 0) ? 32'(m_keys[0]) : 32'h0;
            3'd7: return 32'(n * 256 + (m_ovf ? 8 : 0) + (n == DEPTH ? 4 : 0) + (n == 0 ? 2 : 0));
            default: return 32'h0;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; io_write = 1'b1;
        @(negedge clk);
        io_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; io_read = 1'b1;
        #1 d = rdata;
        @(negedge clk);
        io_read = 1'b0;
    endtask

    task automatic key_push(input logic [KEY_W-1:0] code);
        key_data = code; key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        checks++; if (led_out !== 16'h0) begin errors++; $display("FAIL reset_led: got %h want %h", led_out, 16'h0); end
        checks++; if (seg_data !== 32'h0) begin errors++; $display("FAIL reset_seg: got %h want %h", seg_data, 32'h0); end
        checks++; if (seg_base !== 1'b0) begin errors++; $display("FAIL reset_base: got %b want 0", seg_base); end
        checks++; if (key_pending !== 1'b0) begin errors++; $display("FAIL reset_key_pending: got %b want 0", key_pending); end
        cpu_read(A_STAT, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL reset_key_stat: got %h want %h", d, 32'h2); end
        cpu_read(A_PEND, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_btn_pend: got %h want %h", d, 32'h0); end
    endtask

    task automatic test_led_seg();
        logic [31:0] d;
        cpu_write(A_LED, 32'h0000_A5A5);
        cpu_write(A_SEG, 32'h1234_5678);
        checks++; if (led_out !== 16'hA5A5) begin errors++; $display("FAIL led_write: got %h want %h", led_out, 16'hA5A5); end
        checks++; if (seg_data !== 32'h1234_5678) begin errors++; $display("FAIL seg_write: got %h want %h", seg_data, 32'h1234_5678); end
        cpu_read(A_LED, d);
        checks++; if (d !== 32'h0000_A5A5) begin errors++; $display("FAIL led_read: got %h want %h", d, 32'h0000_A5A5); end
        cpu_read(A_SEG, d);
        checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL seg_read: got %h want %h", d, 32'h1234_5678); end
        addr = A_LED;
        #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rdata_idle: got %h want %h", rdata, 32'h0); end
        #1 rstn = 1'b0;
        #1;
        checks++; if (led_out !== 16'h0) begin errors++; $display("FAIL async_reset_led: got %h want %h", led_out, 16'h0); end
        checks++; if (seg_data !== 32'h0) begin errors++; $display("FAIL async_reset_seg: got %h want %h", seg_data, 32'h0); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_switches();
        logic [31:0] d;
        switch_in = 12'hABC;
        cpu_read(A_SW, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL sw_latency0: got %h want %h", d, 32'h0); end
        cpu_read(A_SW, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL sw_latency1: got %h want %h", d, 32'h0); end
        cpu_read(A_SW, d);
        checks++; if (d !== 32'h0000_0ABC) begin errors++; $display("FAIL sw_latency2: got %h want %h", d, 32'h0000_0ABC); end
        cpu_read(32'hFFFF_FB00, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL addr_miss: got %h want %h", d, 32'h0); end
    endtask

    task automatic test_buttons();
        logic [31:0] d;
        repeat (2) begin
            btn_in[1] = 1'b1; idle(3);
            btn_in[1] = 1'b0; idle(2);
        end
        btn_in[1] = 1'b1;
        // Sampled level reaches the debouncer after 2 edges, then needs 8 stable edges.
        for (int k = 1; k <= 11; k++) begin
            cpu_read(A_PEND, d);
            checks++;
            if (d !== ((k <= 10) ? 32'h0 : 32'h2)) begin
                errors++; $display("FAIL btn_debounce[%0d]: got %h want %h", k, d, (k <= 10) ? 32'h0 : 32'h2);
            end
        end
        cpu_write(A_CLR, 32'h0000_0002);
        cpu_read(A_PEND, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL btn_w1c: got %h want %h", d, 32'h0); end
        btn_in[1] = 1'b0; idle(12);
        btn_in[1] = 1'b1; idle(9);
        cpu_write(A_CLR, 32'h0000_0002);
        cpu_read(A_PEND, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL btn_set_beats_clr: got %h want %h", d, 32'h2); end
        cpu_write(A_CLR, 32'hFFFF_FFFD);
        cpu_read(A_PEND, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL btn_clr_other_bits: got %h want %h", d, 32'h2); end
        cpu_write(A_CLR, 32'h0000_0002);
        cpu_read(A_PEND, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL btn_clr_again: got %h want %h", d, 32'h0); end
    endtask

    task automatic test_key_fifo();
        logic [31:0] d;
        for (int c = 1; c <= 5; c++) key_push(KEY_W'(c));
        cpu_read(A_STAT, d);
        checks++; if (d !== 32'h0000_040C) begin errors++; $display("FAIL key_stat_full_ovf: got %h want %h", d, 32'h0000_040C); end
        checks++; if (key_pending !== 1'b1) begin errors++; $display("FAIL key_pending_set: got %b want 1", key_pending); end
        for (int k = 1; k <= 4; k++) begin
            cpu_read(A_KEY, d);
            checks++; if (d !== 32'(k)) begin errors++; $display("FAIL key_pop[%0d]: got %h want %h", k, d, 32'(k)); end
        end
        cpu_read(A_STAT, d);
        checks++; if (d !== 32'h0000_000A) begin errors++; $display("FAIL key_stat_drained: got %h want %h", d, 32'h0000_000A); end
        cpu_read(A_KEY, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL key_pop_empty: got %h want %h", d, 32'h0); end
        cpu_read(A_STAT, d);
        checks++; if (d !== 32'h0000_000A) begin errors++; $display("FAIL key_stat_after_empty_pop: got %h want %h", d, 32'h0000_000A); end
        cpu_write(A_STAT, 32'h0);
        cpu_read(A_STAT, d);
        checks++; if (d !== 32'h0000_0002) begin errors++; $display("FAIL key_ovf_clear: got %h want %h", d, 32'h0000_0002); end
        checks++; if (key_pending !== 1'b0) begin errors++; $display("FAIL key_pending_clear: got %b want 0", key_pending); end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] d;
        for (int c = 6; c <= 9; c++) key_push(KEY_W'(c));
        key_data = 4'hA; key_valid = 1'b1;
        cpu_read(A_KEY, d);
        key_valid = 1'b0;
        checks++; if (d !== 32'h6) begin errors++; $display("FAIL key_push_pop_head: got %h want %h", d, 32'h6); end
        cpu_read(A_STAT, d);
        checks++; if (d !== 32'h0000_0404) begin errors++; $display("FAIL key_push_pop_stat: got %h want %h", d, 32'h0000_0404); end
        for (int c = 7; c <= 10; c++) begin
            cpu_read(A_KEY, d);
            checks++; if (d !== 32'(c)) begin errors++; $display("FAIL key_drain[%0d]: got %h want %h", c, d, 32'(c)); end
        end
        cpu_read(A_STAT, d);
        checks++; if (d !== 32'h0000_0002) begin errors++; $display("FAIL key_stat_final: got %h want %h", d, 32'h0000_0002); end
    endtask

    task automatic test_seg_base();
        logic [31:0] d;
        cpu_write(A_SEGCTRL, 32'h1);
        checks++; if (seg_base !== 1'b1) begin errors++; $display("FAIL seg_base_set: got %b want 1", seg_base); end
        cpu_read(A_SEGCTRL, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL seg_base_read: got %h want %h", d, 32'h1); end
        cpu_write(A_SEGCTRL, 32'hFFFF_FFFE);
        checks++; if (seg_base !== 1'b0) begin errors++; $display("FAIL seg_base_clr: got %b want 0", seg_base); end
        cpu_read(A_CLR, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL btn_clr_read: got %h want %h", d, 32'h0); end
    endtask

    task automatic test_random();
        logic [31:0] exp;
        int          op;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 15) == 0) switch_in = SW_W'($urandom);
            for (int i = 0; i < NUM_BTN; i++) begin
                if ($urandom_range(0, 9) == 0) btn_in[i] = ~btn_in[i];
            end
            key_valid = ($urandom_range(0, 3) == 0);
            key_data  = KEY_W'($urandom);
            op = $urandom_range(0, 3);
            addr  = ($urandom_range(0, 7) == 0) ? $urandom
                                                : (BASE | {27'b0, 3'($urandom), 2'($urandom)});
            wdata = $urandom;
            io_write = (op == 1);
            io_read  = (op >= 2);
            #1;
            if (io_read) begin
                exp = exp_read(addr);
                checks++;
                if (rdata !== exp) begin
                    errors++; $display("FAIL rand_read[%0d] @%h: got %h want %h", cyc, addr, rdata, exp);
                end
            end
            @(negedge clk);
            io_read = 1'b0; io_write = 1'b0; key_valid = 1'b0;
            checks++;
            if (led_out !== m_led || seg_data !== m_seg || seg_base !== m_base || key_pending !== (m_keys.size() != 0)) begin
                errors++;
                $display("FAIL rand_outputs[%0d]: got led %h seg %h base %b kp %b want led %h seg %h base %b kp %b",
                         cyc, led_out, seg_data, seg_base, key_pending, m_led, m_seg, m_base, m_keys.size() != 0);
            end
        end
    endtask

    task automatic test_reset_midstate();
        logic [31:0] d;
        btn_in = '0;
        idle(12);
        key_push(4'h3);
        key_push(4'h5);
        btn_in[0] = 1'b1;
        idle(5);
        #2 rstn = 1'b0;
        #1;
        checks++; if (key_pending !== 1'b0) begin errors++; $display("FAIL midreset_key_pending: got %b want 0", key_pending); end
        @(negedge clk);
        rstn = 1'b1;
        cpu_read(A_STAT, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL midreset_key_stat: got %h want %h", d, 32'h2); end
        idle(5);
        cpu_read(A_PEND, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_debounce_restart: got %h want %h", d, 32'h0); end
        idle(6);
        cpu_read(A_PEND, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL midreset_debounce_done: got %h want %h", d, 32'h1); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        test_reset();
        test_led_seg();
        test_switches();
        test_buttons();
        test_key_fifo();
        test_push_pop_full();
        test_seg_base();
        test_random();
        test_reset_midstate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_io_bridge.md
Name: mmio_io_bridge

Overview:
- Parametrised memory-mapped I/O bridge between the single-cycle CPU's ioRead/ioWrite datapath and board peripherals: switches, LEDs, the 7-segment data word, debounced push-buttons and the PS/2 key stream.
- Replaces the ad-hoc per-peripheral glue at CPU top level.
- Adds per-button edge capture with write-1-to-clear, a key FIFO with overflow flag, and a software-controlled display radix.

Parameters:
- ADDR_BASE, 32'hFFFF_FC00, base of the 32-byte I/O window; bits [4:2] select the register.
- SW_W, 12, switch width.
- LED_W, 16, LED width.
- NUM_BTN, 4, number of button channels (1..16).
- DEB_CYCLES, 200000, consecutive stable cycles required to accept a button level change.
- KEY_W, 4, key code width.
- KEY_DEPTH, 8, key FIFO depth (power of two, ≥2).

Ports:
- clk  in  1  CPU clock
- rstn  in  1  asynchronous active-low reset
- io_read  in  1  I/O load this cycle
- io_write  in  1  I/O store this cycle
- addr  in  32  byte address from ALU
- wdata  in  32  store data
- rdata  out  32  load data (combinational)
- switch_in  in  SW_W  raw switches
- btn_in  in  NUM_BTN  raw buttons, active-high
- key_data  in  KEY_W  decoded key code
- key_valid  in  1  one-cycle key strobe
- led_out  out  LED_W  LED register
- seg_data  out  32  7-segment data word
- seg_base  out  1  display radix: 0 = hex, 1 = decimal
- key_pending  out  1  FIFO non-empty

Behaviour:
- Address decode
  - Hit when addr[31:5] == ADDR_BASE[31:5].
  - Offsets: 0x00 SW (RO), 0x04 LED (RW), 0x08 SEG (RW), 0x0C SEGCTRL bit0 = base (RW), 0x10 BTN_PEND (RO), 0x14 BTN_CLR (W1C), 0x18 KEY_DATA (RO, pop), 0x1C KEY_STAT (RO; any write clears overflow).
  - Misses, or reads of write-only/unused fields, return 0; writes to RO registers are ignored.
- Reads and writes
  - rdata is combinational from addr when io_read is high, 0 otherwise.
  - All register updates and side effects take effect at the posedge of the same cycle.
  - Narrow registers are zero-extended on read; writes take the low bits.
- Switches
  - Two-flop synchroniser; SW reads return the synchronised value, 2-cycle latency.
- Buttons, per channel
  - Two-flop synchroniser, then debouncer. A counter runs while the synced level ≠ accepted level and clears otherwise.
  - On reaching DEB_CYCLES−1, the accepted level takes the synced level.
  - An accepted 0→1 transition sets pend[i].
  - Writing 1 to BTN_CLR bit i clears pend[i].
  - If set and clear coincide, set wins.
- Key FIFO
  - Circular buffer with wr_ptr, rd_ptr and count (log2(KEY_DEPTH)+1 bits).
  - Push on key_valid when not full. If full, drop the code and set sticky overflow.
  - Pop on io_read at KEY_DATA when not empty. KEY_DATA returns the head code zero-extended, or 0 when empty (no pop).
  - Push and pop in the same cycle: both occur and count is unchanged, including when full (no overflow).
  - Pointers wrap modulo KEY_DEPTH.
  - KEY_STAT = {overflow[3], full[2], empty[1], reserved 0[0]} with count in bits [15:8].
  - key_pending = !empty.
- Reset (asynchronous, rstn low)
  - led_out = 0, seg_data = 0, seg_base = 0.
  - All pend = 0, accepted levels = 0, debounce counters = 0, synchronisers = 0.
  - FIFO empty, overflow = 0, key_pending = 0.
  - rdata follows its combinational rule.
  - A reset mid-debounce or with the FIFO partly full discards all state.
- Cannot-happen conditions
  - io_read and io_write are never high together.
  - io_read is asserted for exactly one cycle per load.

Test Plan:
- Reset then write 0x0000_A5A5 to 0xFFFF_FC04 and 0x1234_5678 to 0xFFFF_FC08 → led_out = 16'hA5A5, seg_data = 32'h1234_5678; reads return the same values. Assert rstn low → both return to 0 immediately.
- switch_in = 12'hABC held → read 0xFFFF_FC00 returns 0x0000_0ABC from the 2nd cycle on; read of 0xFFFF_FB00 returns 0.
- DEB_CYCLES = 8; bounce btn_in[1] 3 cycles high / 2 low, then hold high → BTN_PEND stays 0 until 8 stable cycles after the synchroniser, then becomes 0x2. Write 0x2 to 0xFFFF_FC14 → 0x0. A set coinciding with a clear leaves the bit at 1.
- KEY_DEPTH = 4; push codes 1, 2, 3, 4, 5 → KEY_STAT = 0x0000_040C (count 4, full, overflow). Four KEY_DATA reads return 1, 2, 3, 4, then the status shows empty. A fifth read returns 0 with count unchanged.
- FIFO full; key_valid coincides with a KEY_DATA read → the read returns the oldest code, the new code lands at the tail, count stays 4, overflow is not set. Any write to 0xFFFF_FC1C clears a previously set overflow.
- Write 1 to 0xFFFF_FC0C → seg_base = 1; the read returns 0x1. Write 0xFFFF_FFFE → seg_base = 0.
